led_ctrl_mmio: RTL and testbench

//  Memory-mapped LED controller on the ktc32 data bus; generalises the fixed 4-bit led port of top.

---
 rtl/led_ctrl_pkg.sv | 16 +
 rtl/led_ctrl_mmio_channel.sv | 34 +++
 rtl/led_ctrl_mmio.sv | 113 +++++++++++
 tb/tb_led_ctrl_mmio.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and register-field positions for the memory-mapped LED controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam int unsigned MODE_LSB         = 0;
    localparam int unsigned MODE_MSB         = 1;
    localparam int unsigned DUTY_LSB         = 8;
    localparam int unsigned STATUS_PHASE_BIT = 16;

endpackage

// File: rtl/led_ctrl_mmio_channel.sv
// Per-channel output selector: picks the next LED level from the channel mode,
// the shared blink phase and the PWM compare against the shared counter.
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic [1:0]          mode_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                phase_i,
    output logic                led_o
);

    led_mode_t mode;
    logic      pwm_hit;

    assign mode = led_mode_t'(mode_i);

    // Full-scale duty is forced on so there is no one-step gap per PWM period.
    assign pwm_hit = (duty_i == '1) || (pwm_cnt_i < duty_i);

    always_comb begin
        led_o = 1'b0;
        case (mode)
            LED_OFF:   led_o = 1'b0;
            LED_ON:    led_o = 1'b1;
            LED_BLINK: led_o = phase_i;
            LED_PWM:   led_o = pwm_hit;
            default:   led_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_ctrl_mmio.sv
// Memory-mapped LED controller: per-channel mode/duty registers, shared prescaler,
// PWM and blink timebases, and a registered LED output with a STATUS readback.
module led_ctrl_mmio
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESC      = 50,
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic [NCH-1:0]    led
);

    localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    led_mode_t             mode_q [NCH];
    logic [PWM_BITS-1:0]   duty_q [NCH];
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]    blink_q, blink_d;
    logic                  phase_q, phase_d;
    logic [NCH-1:0]        led_q, led_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  tick;
    logic                  blink_wrap;
    logic                  unused_wdata;

    assign unused_wdata = ^{wdata[31:DUTY_LSB+PWM_BITS], wdata[DUTY_LSB-1:MODE_MSB+1]};

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        blink_wrap = (blink_q == BLINK_LAST);
        blink_d    = blink_wrap ? '0 : blink_q + 1'b1;
        phase_d    = phase_q ^ blink_wrap;
    end

    // Read mux samples registers before any same-cycle write lands.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (addr == ADDR_W'(i)) begin
                    rdata_d[MODE_MSB:MODE_LSB]   = mode_q[i];
                    rdata_d[DUTY_LSB +: PWM_BITS] = duty_q[i];
                end
            end
            if (addr == ADDR_W'(NCH)) begin
                rdata_d[NCH-1:0]          = led_q;
                rdata_d[STATUS_PHASE_BIT] = phase_q;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .mode_i    (mode_q[g]),
            .duty_i    (duty_q[g]),
            .pwm_cnt_i (pwm_cnt_q),
            .phase_i   (phase_q),
            .led_o     (led_d[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                mode_q[i] <= LED_OFF;
                duty_q[i] <= '0;
            end
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            led_q     <= '0;
            rdata_q   <= '0;
        end else begin
            if (we) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (addr == ADDR_W'(i)) begin
                        mode_q[i] <= led_mode_t'(wdata[MODE_MSB:MODE_LSB]);
                        duty_q[i] <= wdata[DUTY_LSB +: PWM_BITS];
                    end
                end
            end
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            rdata_q   <= rdata_d;
        end
    end

    assign led   = led_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_led_ctrl_mmio.sv
// Scoreboard bench for led_ctrl_mmio: a time-based reference model predicts led and
// rdata every cycle; a monitor compares the DUT against the queued predictions.
module tb_led_ctrl_mmio;

    localparam int unsigned NCH        = 4;
    localparam int unsigned PWM_BITS   = 4;
    localparam int unsigned PRESC      = 2;
    localparam int unsigned BLINK_HALF = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] rdata;
    logic [3:0]  led;

    always #5 clk = ~clk;

    led_ctrl_mmio #(
        .NCH        (NCH),
        .PWM_BITS   (PWM_BITS),
        .PRESC      (PRESC),
        .BLINK_HALF (BLINK_HALF),
        .ADDR_W     (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .re    (re),
        .rdata (rdata),
        .led   (led)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0]  led_exp_q [$];
    logic [31:0] rd_exp_q  [$];

    // Reference model: counters derived from elapsed edges since reset release.
    int unsigned m_mode [4];
    int unsigned m_duty [4];
    int unsigned m_edges;
    logic [3:0]  m_led;
    logic [31:0] m_rdata;
    int unsigned ph, pc, a;
    logic [3:0]  nl;
    logic [31:0] rv;

    function automatic logic lit(input int unsigned mode, input int unsigned duty,
                                 input int unsigned phase, input int unsigned pwm);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return phase[0];
            default: return (duty == 15) || (pwm < duty);
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 0;
                m_duty[i] = 0;
            end
            m_edges = 0;
            m_led   = '0;
            m_rdata = '0;
        end else begin
            ph = (m_edges / BLINK_HALF) % 2;
            pc = (m_edges / PRESC) % 16;
            for (int i = 0; i < 4; i++) nl[i] = lit(m_mode[i], m_duty[i], ph, pc);
            a = addr;
            if (a < 4)       rv = m_mode[a] + m_duty[a] * 256;
            else if (a == 4) rv = 32'(m_led) + ph * 65536;
            else             rv = 0;
            if (re) m_rdata = rv;
            if (we && a < 4) begin
                m_mode[a] = wdata[1:0];
                m_duty[a] = wdata[11:8];
            end
            m_led   = nl;
            m_edges = m_edges + 1;
        end
        led_exp_q.push_back(m_led);
        rd_exp_q.push_back(m_rdata);
    end

    logic [3:0]  e_led;
    logic [31:0] e_rd;

    always @(posedge clk) begin
        #1;
        if (led_exp_q.size() == 0 || rd_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e_led = led_exp_q.pop_front();
            e_rd  = rd_exp_q.pop_front();
            vectors++;
            if (led !== e_led) begin
                miscompares++;
                $display("FAIL led t=%0t got=%b exp=%b", $time, led, e_led);
            end
            vectors++;
            if (rdata !== e_rd) begin
                miscompares++;
                $display("FAIL rdata t=%0t got=%h exp=%h", $time, rdata, e_rd);
            end
        end
    end

    task automatic bus(input logic w, input logic r, input logic [5:0] ad, input logic [31:0] d);
        we    = w;
        re    = r;
        addr  = ad;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
        re    = 1'b0;
        wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        addr  = '0;
        wdata = '0;
        idle(3);
        // Writes and reads while held in reset must have no effect.
        bus(1'b1, 1'b0, 6'd1, 32'h1);
        bus(1'b1, 1'b1, 6'd2, 32'h0f03);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) bus(1'b0, 1'b1, 6'(i), '0);

        bus(1'b1, 1'b0, 6'd1, 32'h1);
        idle(2);
        bus(1'b0, 1'b1, 6'd4, '0);

        bus(1'b1, 1'b0, 6'd0, 32'h2);
        idle(40);
        bus(1'b0, 1'b1, 6'd4, '0);

        bus(1'b1, 1'b0, 6'd2, 32'h0403);
        idle(70);
        bus(1'b1, 1'b0, 6'd2, 32'h0003);
        idle(40);
        bus(1'b1, 1'b0, 6'd2, 32'h0f03);
        idle(40);
        bus(1'b0, 1'b1, 6'd2, '0);

        bus(1'b1, 1'b1, 6'd3, 32'h1);
        bus(1'b0, 1'b1, 6'd3, '0);
        bus(1'b1, 1'b0, 6'd9, 32'hffff_ffff);
        bus(1'b0, 1'b1, 6'd9, '0);

        repeat (300) begin
            bus(1'b1 & ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                6'($urandom_range(0, 9)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 5));
        end

        // Asynchronous clear while every channel is lit.
        for (int i = 0; i < 4; i++) bus(1'b1, 1'b0, 6'(i), 32'h1);
        bus(1'b0, 1'b1, 6'd1, '0);
        idle(3);
        vectors++;
        if (led !== 4'b1111) begin
            miscompares++;
            $display("FAIL pre_reset_led got=%b exp=%b", led, 4'b1111);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (led !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_led got=%b exp=%b", led, 4'b0000);
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset_rdata got=%h exp=%h", rdata, 32'h0);
        end
        @(negedge clk);
        idle(3);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) bus(1'b0, 1'b1, 6'(i), '0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
